// File: rtl/aes_result_unloader.sv
// aes_result_unloader: buffers AES cipher blocks (2-deep) and streams each as four 32-bit words, MS word first.
// Optional dropped-block counter port unl_ovf_count enabled by defining AES_UNLOAD_OVF_CNT_EN.
module aes_result_unloader (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic [127:0] AES_data_out,
    input  logic         AES_data_out_valid,
    output logic [31:0]  unl_word,
    output logic         unl_valid,
    input  logic         unl_ready,
    output logic         unl_last,
    output logic         unl_overflow
`ifdef AES_UNLOAD_OVF_CNT_EN
    ,output logic [7:0]  unl_ovf_count
`endif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx_q, idx_d;
    logic         valid_q, arm_q, ovf_q;
    logic         cap, empty, full, pop, push, drop;
    logic [127:0] mem_q [2];
    logic [127:0] head;

    // arm_q blocks a capture on the first edge after reset so a valid already high at release is ignored
    assign cap       = AES_data_out_valid & ~valid_q & arm_q;
    assign empty     = wr_ptr_q == rd_ptr_q;
    assign full      = (wr_ptr_q - rd_ptr_q) == 2'd2;
    assign unl_valid = state_q == SEND;
    assign pop       = unl_valid & unl_ready & (idx_q == 2'd3);
    assign push      = cap & (~full | pop);
    assign drop      = cap & full & ~pop;
    assign head      = mem_q[rd_ptr_q[0]];
    assign unl_last  = unl_valid & (idx_q == 2'd3);
    assign unl_word  = !unl_valid    ? 32'd0 :
                       idx_q == 2'd0 ? head[127:96] :
                       idx_q == 2'd1 ? head[95:64] :
                       idx_q == 2'd2 ? head[63:32] : head[31:0];
    assign unl_overflow = ovf_q;

    // next-state: pointers move on push/pop; a capture into an empty FIFO enters SEND on the same edge
    always_comb begin
        wr_ptr_d = wr_ptr_q + {1'b0, push};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        idx_d    = idx_q + {1'b0, unl_valid & unl_ready};
        state_d  = state_q == IDLE ? ((push || !empty) ? SEND : IDLE)
                                   : ((pop && wr_ptr_d == rd_ptr_d) ? IDLE : SEND);
    end

    // control state with asynchronous clear
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            idx_q    <= 2'd0;
            valid_q  <= 1'b0;
            arm_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            valid_q  <= AES_data_out_valid;
            arm_q    <= 1'b1;
            ovf_q    <= ovf_q | drop;
        end
    end

    // block storage; when full with a simultaneous pop, the freed head slot is the write slot
    always_ff @(posedge AES_clk) begin
        if (push) mem_q[wr_ptr_q[0]] <= AES_data_out;
    end

`ifdef AES_UNLOAD_OVF_CNT_EN
    logic [7:0] cnt_q;

    // saturating count of dropped blocks
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) cnt_q <= 8'd0;
        else if (drop && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
    end

    assign unl_ovf_count = cnt_q;
`endif
endmodule

// File: tb/tb_aes_result_unloader.sv
// tb_aes_result_unloader: table-driven and scoreboard bench for aes_result_unloader.
module tb_aes_result_unloader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] data = '0;
    logic         dvalid = 1'b0;
    logic [31:0]  unl_word;
    logic         unl_valid;
    logic         unl_ready = 1'b0;
    logic         unl_last;
    logic         unl_overflow;
`ifdef AES_UNLOAD_OVF_CNT_EN
    logic [7:0]   unl_ovf_count;
`endif

    typedef struct {
        logic [31:0] w;
        logic        last;
    } exp_t;

    typedef struct {
        logic [127:0] d;
        int           hold;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[4];
    int   n_chk = 0;
    int   n_fail = 0;

    aes_result_unloader dut (
        .AES_clk(clk),
        .AES_rst_n(rst_n),
        .AES_data_out(data),
        .AES_data_out_valid(dvalid),
        .unl_word(unl_word),
        .unl_valid(unl_valid),
        .unl_ready(unl_ready),
        .unl_last(unl_last),
        .unl_overflow(unl_overflow)
`ifdef AES_UNLOAD_OVF_CNT_EN
        ,.unl_ovf_count(unl_ovf_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_block(input logic [127:0] d);
        exp_q.push_back('{d[127:96], 1'b0});
        exp_q.push_back('{d[95:64], 1'b0});
        exp_q.push_back('{d[63:32], 1'b0});
        exp_q.push_back('{d[31:0], 1'b1});
    endtask

    task automatic pulse(input logic [127:0] d);
        data = d;
        dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // scoreboard: every accepted word must be the next expected one; idle outputs must be zero
    always @(negedge clk) begin
        if (unl_valid && unl_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h while no word expected", unl_word);
            end else begin
                mon_e = exp_q.pop_front();
                chk("word", unl_word, mon_e.w);
                chk("last", unl_last, mon_e.last);
            end
        end else if (!unl_valid) begin
            chk("idle_word", unl_word, 0);
            chk("idle_last", unl_last, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{128'h3925841d_02dc09fb_dc118597_196a0b32, 1};
        vecs[1] = '{128'h00112233_44556677_8899aabb_ccddeeff, 10};
        vecs[2] = '{128'hffffffff_00000000_a5a5a5a5_5a5a5a5a, 3};
        vecs[3] = '{128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, 1};

        tick();
        tick();
        chk("rst_valid", unl_valid, 0);
        chk("rst_overflow", unl_overflow, 0);
`ifdef AES_UNLOAD_OVF_CNT_EN
        chk("rst_ovf_count", unl_ovf_count, 0);
`endif
        rst_n = 1'b1;
        tick();

        // table: single captures with ready high, varying valid hold time
        unl_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = vecs[i].d;
            dvalid = 1'b1;
            push_block(vecs[i].d);
            tick();
            chk("lat_valid", unl_valid, 1);
            chk("lat_word0", unl_word, vecs[i].d[127:96]);
            for (int h = 1; h < vecs[i].hold; h++) tick();
            dvalid = 1'b0;
            drain();
            tick();
            tick();
            chk("back_idle", unl_valid, 0);
        end

        // stall at word1 for 5 cycles
        data = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
        dvalid = 1'b1;
        push_block(data);
        tick();
        dvalid = 1'b0;
        tick();
        unl_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("stall_word", unl_word, 32'hcafef00d);
            chk("stall_valid", unl_valid, 1);
            chk("stall_last", unl_last, 0);
        end
        unl_ready = 1'b1;
        drain();
        tick();

        // FIFO full, third capture coincides with the last-word pop: no drop
        unl_ready = 1'b0;
        pulse(128'ha0a0a0a0_a1a1a1a1_a2a2a2a2_a3a3a3a3);
        pulse(128'hb0b0b0b0_b1b1b1b1_b2b2b2b2_b3b3b3b3);
        push_block(128'ha0a0a0a0_a1a1a1a1_a2a2a2a2_a3a3a3a3);
        push_block(128'hb0b0b0b0_b1b1b1b1_b2b2b2b2_b3b3b3b3);
        push_block(128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3);
        unl_ready = 1'b1;
        tick();
        tick();
        tick();
        data = 128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3;
        dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        drain();
        chk("nodrop_overflow", unl_overflow, 0);
`ifdef AES_UNLOAD_OVF_CNT_EN
        chk("nodrop_ovf_count", unl_ovf_count, 0);
`endif
        tick();

        // three captures with ready low: third dropped, first two stream back-to-back
        unl_ready = 1'b0;
        pulse(128'h11111111_12121212_13131313_14141414);
        pulse(128'h21212121_22222222_23232323_24242424);
        pulse(128'h31313131_32323232_33333333_34343434);
        chk("drop_overflow", unl_overflow, 1);
`ifdef AES_UNLOAD_OVF_CNT_EN
        chk("drop_ovf_count", unl_ovf_count, 1);
`endif
        push_block(128'h11111111_12121212_13131313_14141414);
        push_block(128'h21212121_22222222_23232323_24242424);
        unl_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("no_gap_drained", exp_q.size(), 0);
        drain();
        tick();

        // reset during word2, valid held high across release
        data = 128'h55555555_66666666_77777777_88888888;
        dvalid = 1'b1;
        exp_q.push_back('{32'h55555555, 1'b0});
        exp_q.push_back('{32'h66666666, 1'b0});
        tick();
        dvalid = 1'b0;
        tick();
        tick();
        chk("pre_rst_word2", unl_word, 32'h77777777);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", unl_valid, 0);
        chk("arst_word", unl_word, 0);
        chk("arst_last", unl_last, 0);
        chk("arst_overflow", unl_overflow, 0);
`ifdef AES_UNLOAD_OVF_CNT_EN
        chk("arst_ovf_count", unl_ovf_count, 0);
`endif
        dvalid = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("post_rst_idle", unl_valid, 0);
        chk("post_rst_queue", exp_q.size(), 0);
        dvalid = 1'b0;
        tick();
        push_block(128'h0f0e0d0c_0b0a0908_07060504_03020100);
        pulse(128'h0f0e0d0c_0b0a0908_07060504_03020100);
        drain();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
